concat_sched: RTL and testbench
===============================

# concat_sched

Round-robin scheduler that shares the single 50-bit→72-bit Concatinator datapath between two requesters in the 60-bit processor. It accepts operands over valid/ready handshakes and drives the Concatinator's `A` input from a register. It captures the `B` result once the input has settled, then returns the result to the winning requester with a source ID and a tag. It sits between the issue/load units and the shared Concatinator instance, which is instantiated outside this block.

## Interface
- `A_W`, 50, operand width (Concatinator `A`)
- `B_W`, 72, result width (Concatinator `B`)
- `TAG_W`, 4, opaque requester tag width
- `clock` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-high reset
- `req0_valid` in 1: requester 0 has an operand
- `req0_data` in A_W: requester 0 operand
- `req0_tag` in TAG_W: requester 0 tag
- `req0_ready` out 1: requester 0 operand accepted this cycle
- `req1_valid`, `req1_data`, `req1_tag`, `req1_ready`: same as requester 0, for requester 1
- `cat_a` out A_W: registered drive to Concatinator `A`
- `cat_b` in B_W: Concatinator `B` (combinational result of `cat_a`)
- `rsp_valid` out 1: result available
- `rsp_ready` in 1: consumer takes the result
- `rsp_data` out B_W: captured `cat_b`
- `rsp_src` out 1: requester that owns the result (0 or 1)
- `rsp_tag` out TAG_W: tag of that request
- `busy` out 1: high whenever state ≠ IDLE

## Operation
- FSM states are IDLE, DRIVE and HOLD.
- **IDLE:**
  - Grant logic is combinational.
    - Only one valid: grant it.
    - Both valid: grant the requester selected by round-robin pointer `rr`.
  - `reqN_ready` = (state==IDLE) && grant==N. At most one ready is high per cycle. No ready is high when the block is not in IDLE.
  - On accept:
    - `cat_a` ← data.
    - `rsp_tag` ← tag.
    - `rsp_src` ← N.
    - State → DRIVE.
- **DRIVE:**
  - `cat_a` is held stable for one full cycle.
  - At the closing edge: `rsp_data` ← `cat_b`, `rsp_valid` ← 1, state → HOLD.
- **HOLD:**
  - `rsp_valid`, `rsp_data`, `rsp_src` and `rsp_tag` are held stable until `rsp_valid && rsp_ready`.
  - On that handshake: `rsp_valid` ← 0, `rr` ← ~`rsp_src`, state → IDLE.
- `cat_a` keeps the last operand after completion. It changes only on accept.
- `cat_b` is sampled only at the end of DRIVE. Changes on `cat_b` in any other state are ignored.
- Requesters must hold valid, data and tag stable until ready. A valid deasserted before grant is simply not served.

## Timing
- Reset values:
  - State = IDLE, `rr` = 0 (requester 0 favoured first).
  - `cat_a` = 0, `rsp_data` = 0, `rsp_tag` = 0, `rsp_src` = 0.
  - `rsp_valid` = 0, `busy` = 0.
  - `req0_ready` = 0 and `req1_ready` = 0 while reset is asserted.
- Per-transaction timeline, with accept in cycle T:
  - `cat_a` holds the new value in T+1 (DRIVE).
  - `rsp_valid` = 1 from T+2.
  - Latency from accept to `rsp_valid` is 2 cycles.
- With `rsp_ready` held high, the result is taken in T+2, state is IDLE in T+3, and the next accept happens at T+3. Maximum throughput is one operation per 3 cycles.
- Backpressure: HOLD lasts indefinitely while `rsp_ready` = 0, and no new request is accepted.
- Simultaneous valids with continuous demand: grants alternate 0,1,0,1… `rr` updates only on response handshake, never on accept.
- Reset asserted mid-operation (DRIVE or HOLD): the in-flight transaction is discarded and no response is produced. All registers go to their reset values asynchronously.
- `rsp_ready` asserted while `rsp_valid` = 0 has no effect.

## Configuration
- `CONCAT_SCHED_FIXED_PRIO_EN`
  - Defined: fixed priority. Requester 0 always wins when both are valid. `rr` is removed or ignored.
  - Undefined (default): round-robin as described in Operation.
  - All other behaviour and latency are identical in both builds.

## Test plan
- Reset then idle: after `reset` deassert, all outputs are 0 and `busy` = 0. With no valids, the block stays in IDLE with both readies 0.
- Single request: `req0_valid`=1, `req0_data`=70, `req0_tag`=3, `rsp_ready`=1.
  - `req0_ready` pulses in T.
  - `cat_a`=70 in T+1.
  - In T+2: `rsp_valid`=1, `rsp_data`=Concatinator(70), `rsp_src`=0, `rsp_tag`=3.
  - In T+3: `busy`=0.
- Contention: both requesters valid continuously (`req0_data`=70, `req1_data`=48).
  - Default build: grant order 0,1,0,1, one grant every 3 cycles.
  - With `CONCAT_SCHED_FIXED_PRIO_EN`: 0,0,0,…
- Backpressure: hold `rsp_ready`=0 for 10 cycles after `rsp_valid`.
  - Response fields stay constant and both readies stay 0.
  - Raise `rsp_ready`: response completes in one cycle and the next accept follows the cycle after.
- Mid-operation reset: assert `reset` in the DRIVE cycle.
  - Outputs go to 0 immediately and no `rsp_valid` appears.
  - After release, a fresh request behaves as in the single-request scenario.
- `cat_b` glitch: change `cat_b` during HOLD. `rsp_data` keeps the value captured at the end of DRIVE.

Source files
------------

// File: rtl/concat_sched.sv
// Round-robin scheduler sharing one Concatinator between two requesters.
// Define CONCAT_SCHED_FIXED_PRIO_EN to make requester 0 always win ties.
module concat_sched #(
    parameter int A_W   = 50,
    parameter int B_W   = 72,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [A_W-1:0]   req0_data,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [A_W-1:0]   req1_data,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_ready,
    output logic [A_W-1:0]   cat_a,
    input  logic [B_W-1:0]   cat_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [B_W-1:0]   rsp_data,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;
    logic   grant_valid;
    logic   grant_id;
    logic   accept;

`ifndef CONCAT_SCHED_FIXED_PRIO_EN
    logic   rr;
`endif

    // Tie-break: pointer favours the requester that was not served last.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef CONCAT_SCHED_FIXED_PRIO_EN
            grant_id = 1'b0;
`else
            grant_id = rr;
`endif
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign accept     = (state == IDLE) && !reset && grant_valid;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;
    assign busy       = (state != IDLE);

    // cat_b is only trusted at the end of DRIVE, after cat_a has been stable a full cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
`ifndef CONCAT_SCHED_FIXED_PRIO_EN
            rr        <= 1'b0;
`endif
            cat_a     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_src   <= 1'b0;
            rsp_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cat_a   <= grant_id ? req1_data : req0_data;
                        rsp_tag <= grant_id ? req1_tag : req0_tag;
                        rsp_src <= grant_id;
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    rsp_data  <= cat_b;
                    rsp_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
`ifndef CONCAT_SCHED_FIXED_PRIO_EN
                        rr        <= ~rsp_src;
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_concat_sched.sv
// Directed self-checking bench for concat_sched; the Concatinator is a simple stand-in.
module tb_concat_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [49:0] req0_data, req1_data;
    logic [3:0]  req0_tag, req1_tag;
    logic        req0_ready, req1_ready;
    logic [49:0] cat_a;
    logic [71:0] cat_b;
    logic        rsp_valid, rsp_ready;
    logic [71:0] rsp_data;
    logic        rsp_src;
    logic [3:0]  rsp_tag;
    logic        busy;
    logic        glitch;

    int total = 0;
    int bad   = 0;

    // Stand-in Concatinator: {a[21:0] ^ 22'h2AAAAA, a}
    localparam logic [71:0] EXP70 = {22'h2AAAEC, 50'd70};
    localparam logic [71:0] EXP48 = {22'h2AAA9A, 50'd48};

    assign cat_b = glitch ? 72'hDE_ADBE_EFDE_ADBE_EF12 : {cat_a[21:0] ^ 22'h2AAAAA, cat_a};

    always #5 clock = ~clock;

    concat_sched dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_tag(req0_tag), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_tag(req1_tag), .req1_ready(req1_ready),
        .cat_a(cat_a), .cat_b(cat_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_src(rsp_src), .rsp_tag(rsp_tag), .busy(busy)
    );

    task automatic checkOutput(input string tag, input logic [71:0] actual, input logic [71:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full transaction with rsp_ready high, checked cycle by cycle from accept.
    task automatic applyStimulus(input logic src, input logic [49:0] data, input logic [3:0] tag,
                                 input logic [71:0] exp_b);
        if (src) begin
            req1_valid = 1'b1; req1_data = data; req1_tag = tag;
        end else begin
            req0_valid = 1'b1; req0_data = data; req0_tag = tag;
        end
        #1;
        checkOutput("acc_ready0", req0_ready, !src);
        checkOutput("acc_ready1", req1_ready, src);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("drv_cat_a", cat_a, data);
        checkOutput("drv_busy", busy, 1'b1);
        checkOutput("drv_rsp_valid", rsp_valid, 1'b0);
        step();
        checkOutput("rsp_valid", rsp_valid, 1'b1);
        checkOutput("rsp_data", rsp_data, exp_b);
        checkOutput("rsp_src", rsp_src, src);
        checkOutput("rsp_tag", rsp_tag, tag);
        step();
        checkOutput("done_busy", busy, 1'b0);
        checkOutput("done_rsp_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          grants;
        int          last_k;
        logic        exp_gid;
        logic        gid;

        reset = 1'b1; glitch = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 50'd70; req0_tag = 4'd3;
        req1_valid = 1'b0; req1_data = '0; req1_tag = '0;
        #2;
        checkOutput("reset_ready0", req0_ready, 1'b0);
        checkOutput("reset_ready1", req1_ready, 1'b0);
        step();
        step();
        reset = 1'b0;
        req0_valid = 1'b0;
        #1;
        checkOutput("rst_cat_a", cat_a, 50'd0);
        checkOutput("rst_rsp_data", rsp_data, 72'd0);
        checkOutput("rst_rsp_tag", rsp_tag, 4'd0);
        checkOutput("rst_rsp_src", rsp_src, 1'b0);
        checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("idle_ready0", req0_ready, 1'b0);
            checkOutput("idle_ready1", req1_ready, 1'b0);
            checkOutput("idle_busy", busy, 1'b0);
        end

        rsp_ready = 1'b1;
        applyStimulus(1'b0, 50'd70, 4'd3, EXP70);

        // Contention from a fresh reset so the pointer starts at requester 0.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        step();
        req0_valid = 1'b1; req0_data = 50'd70; req0_tag = 4'd1;
        req1_valid = 1'b1; req1_data = 50'd48; req1_tag = 4'd2;
        #1;
        grants = 0;
        last_k = 0;
        for (int k = 0; k < 16 && grants < 4; k++) begin
            if (k > 0) step();
            checkOutput("cont_one_ready", req0_ready && req1_ready, 1'b0);
            if (rsp_valid) begin
                checkOutput("cont_rsp_data", rsp_data, rsp_src ? EXP48 : EXP70);
                checkOutput("cont_rsp_tag", rsp_tag, rsp_src ? 4'd2 : 4'd1);
            end
            if (req0_ready || req1_ready) begin
                gid = req1_ready;
`ifdef CONCAT_SCHED_FIXED_PRIO_EN
                exp_gid = 1'b0;
`else
                exp_gid = grants[0];
`endif
                checkOutput("cont_grant_id", gid, exp_gid);
                if (grants > 0) checkOutput("cont_spacing", 72'(k - last_k), 72'd3);
                last_k = k;
                grants++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("cont_grant_count", 72'(grants), 72'd4);
        step();
        step();
        step();
        checkOutput("cont_idle", busy, 1'b0);

        // Backpressure, with a cat_b glitch while the result is held.
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_data = 50'd48; req1_tag = 4'd9;
        #1;
        checkOutput("bp_accept", req1_ready, 1'b1);
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_data = 50'd70; req0_tag = 4'd4;
        step();
        for (int i = 0; i < 10; i++) begin
            if (i == 4) glitch = 1'b1;
            checkOutput("bp_rsp_valid", rsp_valid, 1'b1);
            checkOutput(i >= 4 ? "glitch_rsp_data" : "bp_rsp_data", rsp_data, EXP48);
            checkOutput("bp_rsp_src", rsp_src, 1'b1);
            checkOutput("bp_rsp_tag", rsp_tag, 4'd9);
            checkOutput("bp_ready0", req0_ready, 1'b0);
            checkOutput("bp_ready1", req1_ready, 1'b0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        glitch = 1'b0;
        checkOutput("bp_release_valid", rsp_valid, 1'b0);
        checkOutput("bp_release_busy", busy, 1'b0);
        checkOutput("bp_next_ready0", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        checkOutput("bp_next_cat_a", cat_a, 50'd70);
        step();
        checkOutput("bp_next_rsp_src", rsp_src, 1'b0);
        checkOutput("bp_next_rsp_tag", rsp_tag, 4'd4);
        checkOutput("bp_next_rsp_data", rsp_data, EXP70);
        step();

        // Reset during DRIVE drops the transaction.
        req0_valid = 1'b1; req0_data = 50'd70; req0_tag = 4'd5;
        #1;
        checkOutput("mid_accept", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        checkOutput("mid_drive_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("mid_cat_a", cat_a, 50'd0);
        checkOutput("mid_busy", busy, 1'b0);
        checkOutput("mid_rsp_valid", rsp_valid, 1'b0);
        checkOutput("mid_rsp_tag", rsp_tag, 4'd0);
        checkOutput("mid_ready0", req0_ready, 1'b0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("mid_no_rsp", rsp_valid, 1'b0);
        end
        applyStimulus(1'b0, 50'd70, 4'd3, EXP70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
